// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - EX-stage request/response bundle for the M-extension sequencer
interface muldiv_seq_if #(parameter int XLEN = 32);
  logic            valid_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multi-cycle multiply / restoring divide sequencer with EX stall
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, quo, rem, dvsr, result;
  logic [4:0]      cnt;
  logic            done;

  function automatic logic [XLEN-1:0] mag(input logic neg, input logic [XLEN-1:0] x);
    return neg ? -x : x;
  endfunction

  // Sign fixup of the magnitude quotient/remainder; the two special cases override it.
  function automatic logic [XLEN-1:0] div_result(input logic [2:0] f,
                                                 input logic [XLEN-1:0] x, y, q, r);
    logic            sgn, xn, yn;
    logic [XLEN-1:0] qf, rf;
    sgn = ~f[0];
    xn  = sgn & x[XLEN-1];
    yn  = sgn & y[XLEN-1];
    qf  = (xn ^ yn) ? -q : q;
    rf  = xn ? -r : r;
    if (y == '0) begin
      qf = '1;
      rf = x;
    end else if (sgn && x == INT_MIN && y == '1) begin
      qf = INT_MIN;
      rf = '0;
    end
    return f[1] ? rf : qf;
  endfunction

  // 33-bit extended operands, widened to the full product width so the low bits are exact.
  logic                sa, sb;
  logic [2*XLEN+1:0]   a_wide, b_wide, prod;
  logic [XLEN-1:0]     mul_res;
  assign sa      = (op == 3'd1) || (op == 3'd2);
  assign sb      = (op == 3'd1);
  assign a_wide  = {{(XLEN+2){sa & a[XLEN-1]}}, a};
  assign b_wide  = {{(XLEN+2){sb & b[XLEN-1]}}, b};
  assign prod    = a_wide * b_wide;
  assign mul_res = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic            take;
  logic [XLEN-1:0] rem_nxt, quo_nxt;
  assign rem_sh  = {rem, quo[XLEN-1]};
  assign diff    = {1'b0, rem_sh} - {2'b00, dvsr};
  assign take    = ~diff[XLEN+1];
  assign rem_nxt = take ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nxt = {quo[XLEN-2:0], take};

  logic unused_bits;
  assign unused_bits = ^{prod[2*XLEN+1:2*XLEN], diff[XLEN]};

`ifdef MULDIV_EARLY_OUT_EN
  logic early;
  assign early = (bus.rs2_i == '0) ||
                 (!bus.op_i[0] && bus.rs1_i == INT_MIN && bus.rs2_i == '1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= '0;
      a      <= '0;
      b      <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_i && !bus.flush_i) begin
            op   <= bus.op_i;
            a    <= bus.rs1_i;
            b    <= bus.rs2_i;
            cnt  <= '0;
            rem  <= '0;
            quo  <= mag(~bus.op_i[0] & bus.rs1_i[XLEN-1], bus.rs1_i);
            dvsr <= mag(~bus.op_i[0] & bus.rs2_i[XLEN-1], bus.rs2_i);
            if (!bus.op_i[2]) begin
              state <= MUL;
`ifdef MULDIV_EARLY_OUT_EN
            end else if (early) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= div_result(bus.op_i, bus.rs1_i, bus.rs2_i, '0, '0);
`endif
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            result <= mul_res;
          end
        end
        DIV: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= div_result(op, a, b, quo_nxt, rem_nxt);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall_o  = (state == IDLE && bus.valid_i && !bus.flush_i) ||
                        state == MUL || state == DIV;
  assign bus.busy_o   = (state != IDLE);
  assign bus.done_o   = done;
  assign bus.result_o = result;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq (results, latency, flush, reset)
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus ();
  muldiv_seq #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          cyc_q[$];
  string       tag_q[$];
  logic [31:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, y);
    logic [63:0] p;
    int          si, sj;
    si = x;
    sj = y;
    case (op)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      3'd2: begin p = {{32{x[31]}}, x} * {32'b0, y}; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      default: begin
        if (y == 32'd0) return op[1] ? x : 32'hFFFF_FFFF;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
          3'd4:    return si / sj;
          3'd5:    return x / y;
          3'd6:    return si % sj;
          default: return x % y;
        endcase
      end
    endcase
  endfunction

  function automatic int lat(input logic [2:0] op, input logic [31:0] x, y);
    if (!op[2]) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (y == 32'd0 || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  task automatic expect_res(input logic [2:0] op, input logic [31:0] x, y, input int at);
    exp_q.push_back(model(op, x, y));
    cyc_q.push_back(at);
    tag_q.push_back($sformatf("op%0d_%h_%h", op, x, y));
  endtask

  // Compares every done_o strobe against the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    int          c;
    string       t;
    if (bus.done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("extra_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        t = tag_q.pop_front();
        check({t, "_result"}, bus.result_o, e);
        check({t, "_latency"}, cyc, c);
        check({t, "_stall_done"}, {31'b0, bus.stall_o}, 32'd0);
        last_res = e;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("timeout", 32'd1, 32'd0);
      exp_q.delete();
      cyc_q.delete();
      tag_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] x, y);
    bus.valid_i = v;
    bus.op_i    = op;
    bus.rs1_i   = x;
    bus.rs2_i   = y;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, y);
    @(negedge clk);
    drive(1'b1, op, x, y);
    expect_res(op, x, y, cyc + lat(op, x, y));
    @(negedge clk);
    bus.valid_i = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {31'b0, bus.busy_o},  32'd0);
    check({tag, "_done"},   {31'b0, bus.done_o},  32'd0);
    check({tag, "_stall"},  {31'b0, bus.stall_o}, 32'd0);
    check({tag, "_result"}, bus.result_o,         32'd0);
  endtask

  initial begin
    int k;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2);
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000);
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2);
    run_op(3'd5, 32'd100,        32'd7);
    run_op(3'd7, 32'd100,        32'd7);
    run_op(3'd4, 32'd7,          32'hFFFF_FFFE);
    run_op(3'd6, 32'd7,          32'hFFFF_FFFE);
    run_op(3'd5, 32'd5,          32'd0);
    run_op(3'd6, 32'd5,          32'd0);
    run_op(3'd4, 32'hFFFF_FFFB,  32'd0);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op(3'd7, 32'h8000_0000,  32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++)
      run_op({2'b10, i[0]} | 3'd5, $urandom, $urandom_range(1, 1000));

    // Flush a divide at T+10: no strobe, outputs idle, result held.
    @(negedge clk);
    drive(1'b1, 3'd4, 32'd1000, 32'd3);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("div_busy", {31'b0, bus.busy_o},  32'd1);
    check("div_stall", {31'b0, bus.stall_o}, 32'd1);
    repeat (5) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy",   {31'b0, bus.busy_o},  32'd0);
    check("flush_stall",  {31'b0, bus.stall_o}, 32'd0);
    check("flush_result", bus.result_o,         last_res);
    repeat (40) @(negedge clk);

    // Flush together with valid in IDLE blocks the start.
    drive(1'b1, 3'd0, 32'd3, 32'd4);
    bus.flush_i = 1'b1;
    check("flush_idle_stall", {31'b0, bus.stall_o}, 32'd0);
    @(negedge clk);
    check("flush_idle_busy", {31'b0, bus.busy_o}, 32'd0);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back: valid held; operands changed mid-divide start the follow-on MUL.
    k = cyc;
    drive(1'b1, 3'd6, 32'hFFFF_FFF9, 32'd2);
    expect_res(3'd6, 32'hFFFF_FFF9, 32'd2, k + 33);
    @(negedge clk);
    drive(1'b1, 3'd0, 32'd6, 32'd7);
    expect_res(3'd0, 32'd6, 32'd7, k + 36);
    while (cyc < k + 35) @(negedge clk);
    bus.valid_i = 1'b0;
    wait_idle();

    // Reset in the middle of a divide.
    @(negedge clk);
    drive(1'b1, 3'd5, 32'd1234, 32'd5);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    last_res = '0;
    repeat (40) @(negedge clk);
    run_op(3'd0, 32'd7, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage of the 5-stage pipeline. Accepts an M-extension op from EX, latches operands, runs a registered multiply or a 32-iteration restoring divide, and holds the pipeline with `stall_o` until the result is ready. It also owns the hazard handshake between EX and the shared arithmetic resource, and `flush_i` handling.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  EX holds an M-extension instruction.
- `op_i`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_i`  in  XLEN  operand A (dividend / multiplicand).
- `rs2_i`  in  XLEN  operand B (divisor / multiplier).
- `flush_i`  in  1  abort current op (branch/trap flush of EX).
- `stall_o`  out  1  freeze IF/ID/EX (combinational).
- `busy_o`  out  1  state is not IDLE (registered).
- `done_o`  out  1  one-cycle result strobe (registered).
- `result_o`  out  XLEN  result; held until next `done_o`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: `valid_i`=1 and `flush_i`=0 → latch `op_i`, `rs1_i`, `rs2_i`; go to MUL (op<4) or DIV (op≥4).
- MUL: one cycle; 33-bit extended operands (signed for MULH; A signed/B unsigned for MULHSU; unsigned for MULHU) → 66-bit product; MUL takes bits [31:0], others take [63:32]; go to DONE.
- DIV: restoring shift-subtract on magnitudes, one quotient bit per cycle, 5-bit iteration counter 0..31; after iteration 31 go to DONE.
- Signed fixup in DONE entry: quotient negated when sign(A)≠sign(B); remainder takes sign of A.
- Special cases override fixup: B=0 → quotient 0xFFFFFFFF, remainder = A; signed A=0x80000000, B=0xFFFFFFFF → quotient 0x80000000, remainder 0.
- DONE: `done_o`=1, `result_o` valid; `valid_i` ignored; always return to IDLE.
- `stall_o` = (IDLE & `valid_i` & ~`flush_i`) | MUL | DIV. Low in DONE so EX advances.
- `flush_i` in MUL/DIV/DONE: next state IDLE, no `done_o`, `result_o` unchanged. `flush_i` in IDLE blocks a start.
- `valid_i`/operand changes during MUL/DIV ignored (operands latched).

## Timing
- Reset: state IDLE, `busy_o`=0, `done_o`=0, `stall_o`=0 (given `valid_i`=0), `result_o`=0, counter 0. Reset mid-op aborts with no `done_o`.
- Start cycle T (IDLE, `valid_i`=1).
- Multiply: MUL at T+1, DONE at T+2; `stall_o` high T, T+1; `done_o` at T+2.
- Divide: DIV at T+1..T+32, DONE at T+33; 33 stall cycles.
- Back-to-back: next op may start in the cycle after DONE (IDLE); no idle gap beyond that one cycle.
- `rst` has priority over `flush_i`, which has priority over `valid_i`.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: divide-by-zero and signed overflow detected in IDLE at start; state goes IDLE→DONE directly, `done_o` at T+1, 1 stall cycle.
- Undefined: special cases run full 32 iterations, `done_o` at T+33; results identical either way.

## Test plan
- MUL A=7, B=0xFFFFFFFD → `result_o`=0xFFFFFFEB, `done_o` at T+2; MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFD at T+33; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- DIVU A=5, B=0 → 0xFFFFFFFF; REM A=5, B=0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; `done_o` at T+1 with macro, T+33 without.
- `flush_i` at T+10 of a DIV → IDLE at T+11, no `done_o`, `stall_o` low, `result_o` unchanged; `flush_i`+`valid_i` in IDLE → no start.
- Back-to-back DIV then MUL with `valid_i` held → second starts cycle after first DONE; exactly one `done_o` per op, correct results.
- `rst` asserted mid-DIV → next cycle all outputs at reset values; subsequent MUL completes normally.
